// File: rtl/ahb_pkg.sv
// Shared AHB encodings, slave FSM state type and timeout counter width for ahb_slave_if.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CAPT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } slv_state_t;

endpackage

// File: rtl/ahb_slave_if_if.sv
// AHB bus bundle between the decoder/mux (master modport) and ahb_slave_if (slave modport).
interface ahb_slave_if_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_slv_align_chk.sv
// Combinational alignment check of an address phase: flags sizes above word and
// half/word accesses not aligned to their natural boundary.
module ahb_slv_align_chk
  import ahb_pkg::*;
(
  input  logic [1:0] haddr_i,
  input  logic [2:0] hsize_i,
  output logic       misalign_o
);

  always_comb begin
    misalign_o = 1'b0;
    if (hsize_i > HSIZE_WORD) begin
      misalign_o = 1'b1;
    end else if (hsize_i == HSIZE_HALF) begin
      misalign_o = haddr_i[0];
    end else if (hsize_i == HSIZE_WORD) begin
      misalign_o = |haddr_i;
    end
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB responder bridge: each accepted transfer becomes one LocalReq/LocalAck access (2 wait states min).
// Define AHB_SLV_ALIGN_CHK_EN to reject misaligned/oversized address phases with ERROR.
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                RST_N,
  ahb_slave_if_if.slave       bus,
  input  logic                Busy,
  output logic                LocalReq,
  output logic                LocalWr,
  output logic [31:0]         LocalAddr,
  output logic [2:0]          LocalSize,
  output logic [31:0]         LocalWData,
  input  logic [31:0]         LocalRData,
  input  logic                LocalAck,
  input  logic                LocalErr
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  slv_state_t       state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hrdata_q, hrdata_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       size_q, size_d;
  logic             wr_q, wr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic addr_vld;
  logic align_err;

  // Only NONSEQ/SEQ carry a transfer; IDLE/BUSY fall through to a zero-wait OKAY.
  assign addr_vld = bus.HSEL && bus.HREADY &&
                    ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));

`ifdef AHB_SLV_ALIGN_CHK_EN
  ahb_slv_align_chk u_align_chk (
    .haddr_i    (bus.HADDR[1:0]),
    .hsize_i    (bus.HSIZE),
    .misalign_o (align_err)
  );
`else
  assign align_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      code_q   <= HRESP_OKAY;
      cnt_q    <= '0;
      hrdata_q <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      hrdata_q <= hrdata_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    hrdata_d = hrdata_q;
    addr_d   = addr_q;
    size_d   = size_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;

    unique case (state_q)
      // States where the bus sees HREADYOUT=1 and may start the next transfer.
      ST_IDLE, ST_RESP, ST_ERR2: begin
        state_d = ST_IDLE;
        if (addr_vld) begin
          if (align_err) begin
            state_d = ST_ERR1;
            code_d  = HRESP_ERROR;
          end else if (Busy) begin
            state_d = ST_ERR1;
            code_d  = HRESP_RETRY;
          end else begin
            addr_d  = bus.HADDR;
            size_d  = bus.HSIZE;
            wr_d    = bus.HWRITE;
            state_d = ST_CAPT;
          end
        end
      end
      ST_CAPT: begin
        wdata_d = bus.HWDATA;
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (LocalAck) begin
          if (LocalErr) begin
            state_d = ST_ERR1;
            code_d  = HRESP_ERROR;
          end else begin
            if (!wr_q) begin
              hrdata_d = LocalRData;
            end
            state_d = ST_RESP;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_ERR1;
          code_d  = HRESP_ERROR;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode the registered state so an async reset clears them at once.
  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = HRESP_OKAY;
    LocalReq      = 1'b0;
    unique case (state_q)
      ST_CAPT:   bus.HREADYOUT = 1'b0;
      ST_ACCESS: begin
        bus.HREADYOUT = 1'b0;
        LocalReq      = 1'b1;
      end
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = code_q;
      end
      ST_ERR2:   bus.HRESP = code_q;
      default:   bus.HREADYOUT = 1'b1;
    endcase
  end

  assign bus.HRDATA = hrdata_q;
  assign LocalWr    = wr_q;
  assign LocalAddr  = addr_q;
  assign LocalSize  = size_q;
  assign LocalWData = wdata_q;

endmodule

// File: doc/ahb_slave_if.md
# ahb_slave_if

Responder-side AHB bridge. Accepts AHB transfers addressed to this slave (HSEL), converts each into a single-request/acknowledge local access toward a register file or memory client, and returns data and an OKAY, ERROR or RETRY response on the bus. It is the slave-end counterpart of the DMA master interface and sits between the AHB decoder/mux and local peripherals.

## Interface
Parameters:
- TIMEOUT, 255: maximum ACCESS cycles without LocalAck before an ERROR response; 8-bit counter.

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- HSEL  in  1  slave select
- HADDR  in  32  address-phase address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1=write
- HSIZE  in  3  0=byte, 1=half, 2=word
- HWDATA  in  32  write data, data phase
- HREADY  in  1  bus-wide ready; address phase accepted only when high
- HREADYOUT  out  1  this slave's ready
- HRESP  out  2  OKAY=00, ERROR=01, RETRY=10; SPLIT never driven
- HRDATA  out  32  read data, registered
- Busy  in  1  client cannot accept a new access; causes RETRY
- LocalReq  out  1  access request, held until LocalAck
- LocalWr  out  1  1=write
- LocalAddr  out  32  registered HADDR
- LocalSize  out  3  registered HSIZE
- LocalWData  out  32  HWDATA, registered at ACCESS entry
- LocalRData  in  32  read data, valid with LocalAck
- LocalAck  in  1  access complete
- LocalErr  in  1  with LocalAck: access failed

## Operation
- Address phase is valid when HSEL && HREADY && HTRANS[1]. Valid phases are accepted only in IDLE, RESP or ERR2. IDLE and BUSY transfers get a zero-wait OKAY.
- States:
  - IDLE: HREADYOUT=1, HRESP=OKAY.
    - Valid phase with Busy=1 goes to ERR1 with code RETRY.
    - Otherwise LocalAddr, LocalSize and LocalWr are registered and the FSM goes to CAPT.
  - CAPT: data-phase cycle 1, HREADYOUT=0. LocalWData is registered from HWDATA. Go to ACCESS.
  - ACCESS: LocalReq=1, HREADYOUT=0, timeout counter increments.
    - LocalAck && !LocalErr: capture LocalRData into HRDATA on reads, go to RESP.
    - LocalAck && LocalErr: go to ERR1 with code ERROR.
    - Counter reaches TIMEOUT without LocalAck: drop LocalReq, go to ERR1 with code ERROR.
  - RESP: HREADYOUT=1, HRESP=OKAY. A valid phase is handled as in IDLE; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=code.
  - ERR2: HREADYOUT=1, HRESP=code. A valid phase is handled as in IDLE; otherwise go to IDLE.
- Timeout counter clears on ACCESS entry.
- HRDATA holds its value between reads. It is not updated on writes or errors.
- LocalAck outside ACCESS is ignored.

## Timing
- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, LocalReq=0, LocalWr=0, LocalAddr=0, LocalSize=0, LocalWData=0, state IDLE, counter 0.
- Minimum transfer with the client acking in its first ACCESS cycle: 3 data-phase cycles (CAPT, ACCESS, RESP). That is 2 wait states.
- ERROR/RETRY: exactly two cycles, low-ready then high-ready, same HRESP code in both.
- RETRY is decided in the address phase and adds no LocalReq.
- Back-to-back transfers: the next address phase overlaps RESP or ERR2. There are no idle cycles between transfers.
- HREADY low from another slave in IDLE, RESP or ERR2: no capture.
- Async reset mid-ACCESS: LocalReq drops immediately and the client access is abandoned.
- TIMEOUT=255, client never acks: LocalReq is high for 255 cycles, then ERR1.

## Configuration
- AHB_SLV_ALIGN_CHK_EN defined:
  - A valid address phase is checked before Busy. HSIZE>2, half with HADDR[0]=1, or word with HADDR[1:0]≠0 fails the check.
  - A failed check goes to ERR1 with code ERROR. No LocalReq is issued and LocalAddr is not updated.
- Undefined: no check; every access is forwarded unchanged.

## Structure
- Package ahb_pkg holds:
  - HTRANS, HRESP and HSIZE constants.
  - State encoding (IDLE, CAPT, ACCESS, RESP, ERR1, ERR2; 3 bits).
  - Timeout counter width.
- One sub-module, ahb_slv_align_chk: combinational HADDR/HSIZE check, instantiated only under AHB_SLV_ALIGN_CHK_EN.

## Test plan
- Word write 0x1000 ← 0xA5A5_0001, LocalAck in the first ACCESS cycle:
  - LocalReq for 1 cycle with LocalAddr=0x1000, LocalWData=0xA5A5_0001.
  - HREADYOUT low 2 cycles, then OKAY.
- Read 0x2004, LocalAck after 3 cycles with LocalRData=0xDEAD_BEEF:
  - HRDATA=0xDEAD_BEEF in RESP with HRESP=00.
  - HRDATA holds that value on a following write.
- Busy=1 during a NONSEQ phase: HRESP=10 for 2 cycles (HREADYOUT 0 then 1), no LocalReq.
- Client never acks, TIMEOUT=4: LocalReq high 4 cycles, then two-cycle ERROR; a later access completes OKAY.
- With AHB_SLV_ALIGN_CHK_EN, word access at 0x1002: two-cycle ERROR, no LocalReq. Without the macro: forwarded with LocalAddr=0x1002.
- Four-beat SEQ burst with immediate acks: four LocalReq pulses, addresses 0x3000..0x300C, each beat overlapping the previous RESP. Then assert RST_N low mid-ACCESS: HREADYOUT=1 and LocalReq=0 immediately.
